// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, turns EX branches into
// flush + PC redirect, and defers the redirect past an outstanding instruction fetch.
module pipe_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              fetch_kill_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic {RUN, WAIT_FETCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [5:0]        stall_vec;
  logic              tgt_ld;

  // Each requester freezes its own stage and everything upstream of it.
  always_comb begin
    stall_vec = '0;
    if (stallreq_mem_i) stall_vec = stall_vec | 6'b011111;
    if (stallreq_ex_i)  stall_vec = stall_vec | 6'b001111;
    if (stallreq_id_i)  stall_vec = stall_vec | 6'b000111;
    if (stallreq_if_i || state_q == WAIT_FETCH) stall_vec = stall_vec | 6'b000011;
    if (rst) stall_vec = '0;
  end

  always_comb begin
    state_d          = state_q;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = tgt_q;
    fetch_kill_o     = 1'b0;
    tgt_ld           = 1'b0;
    unique case (state_q)
      RUN: begin
        // A stalled EX/MEM boundary means EX will re-present the branch later.
        if (branch_taken_i && !stall_vec[3]) begin
          flush_o = 1'b1;
          if (stallreq_if_i) begin
            tgt_ld  = 1'b1;
            state_d = WAIT_FETCH;
          end else begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = branch_target_i;
          end
        end
      end
      WAIT_FETCH: begin
        fetch_kill_o = 1'b1;
        if (!stallreq_if_i) begin
          redirect_valid_o = 1'b1;
          state_d          = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      state_d          = RUN;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      fetch_kill_o     = 1'b0;
      tgt_ld           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (tgt_ld) tgt_q <= branch_target_i;
      if (stall_vec[0] && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_o     = stall_vec;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of pending redirects and a saturating stall counter.
module tb_pipe_ctrl;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [5:0]        stall_o;
  logic              flush_o, redirect_valid_o, fetch_kill_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .fetch_kill_o(fetch_kill_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: whether a redirect is owed once the fetch returns, its target, and the counter.
  bit              m_pend;
  logic [63:0]     m_tgt;
  int              m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Drive one cycle's inputs at the falling edge, check against the model, then advance it.
  task automatic cyc(input bit r, input bit rif, input bit rid, input bit rex,
                     input bit rmem, input bit br, input logic [63:0] tgt);
    logic [5:0]  e_stall;
    bit          e_flush, e_rv, e_kill, acc;
    logic [63:0] e_pc;
    @(negedge clk);
    rst = r; stallreq_if_i = rif; stallreq_id_i = rid; stallreq_ex_i = rex;
    stallreq_mem_i = rmem; branch_taken_i = br; branch_target_i = tgt;
    #1;
    e_stall = '0; e_flush = 0; e_rv = 0; e_kill = 0; e_pc = '0;
    if (!r) begin
      if (rmem) e_stall |= 6'b011111;
      if (rex)  e_stall |= 6'b001111;
      if (rid)  e_stall |= 6'b000111;
      if (rif || m_pend) e_stall |= 6'b000011;
      e_pc = m_tgt;
      if (m_pend) begin
        e_kill = 1;
        e_rv   = !rif;
      end else begin
        acc     = br && !e_stall[3];
        e_flush = acc;
        e_rv    = acc && !rif;
        if (e_rv) e_pc = tgt;
      end
    end
    chk("stall", 64'(stall_o), 64'(e_stall));
    chk("flush", 64'(flush_o), 64'(e_flush));
    chk("redirect_valid", 64'(redirect_valid_o), 64'(e_rv));
    chk("redirect_pc", redirect_pc_o, e_pc);
    chk("fetch_kill", 64'(fetch_kill_o), 64'(e_kill));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    if (r) begin
      m_pend = 0; m_tgt = '0; m_cnt = 0;
    end else begin
      if (m_pend) begin
        if (!rif) m_pend = 0;
      end else if (br && !e_stall[3] && rif) begin
        m_pend = 1; m_tgt = tgt;
      end
      if (e_stall[0] && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 64'h0); endtask
  task automatic do_rst(); cyc(1, 0, 0, 0, 0, 0, 64'h0); endtask

  initial begin
    rst = 1; stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0;
    stallreq_mem_i = 0; branch_taken_i = 0; branch_target_i = '0;
    m_pend = 0; m_tgt = '0; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    do_rst();
    chk("reset_stall", 64'(stall_o), 64'h0);
    chk("reset_cnt", 64'(stall_cnt_o), 64'h0);

    // Stall priority and counter advance
    do_rst();
    cyc(0, 0, 1, 0, 1, 0, 64'h0);
    chk("prio_mem_id", 64'(stall_o), 64'h1F);
    cyc(0, 0, 1, 0, 0, 0, 64'h0);
    chk("prio_id", 64'(stall_o), 64'h07);
    idle();
    chk("prio_none", 64'(stall_o), 64'h0);
    chk("prio_cnt2", 64'(stall_cnt_o), 64'd2);

    // Clean branch
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0040);
    chk("clean_flush", 64'(flush_o), 64'h1);
    chk("clean_rv", 64'(redirect_valid_o), 64'h1);
    chk("clean_pc", redirect_pc_o, 64'h8000_0040);
    idle();
    chk("clean_flush_off", 64'(flush_o), 64'h0);
    chk("clean_rv_off", 64'(redirect_valid_o), 64'h0);

    // Branch under an outstanding fetch
    cyc(0, 1, 0, 0, 0, 1, 64'h8000_0100);
    chk("miss_flush", 64'(flush_o), 64'h1);
    chk("miss_rv", 64'(redirect_valid_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 1, 64'hDEAD_0000);
      chk("miss_kill", 64'(fetch_kill_o), 64'h1);
      chk("miss_stall", 64'(stall_o), 64'h03);
      chk("miss_noflush", 64'(flush_o), 64'h0);
    end
    cyc(0, 0, 0, 0, 0, 0, 64'h0);
    chk("miss_rv_on", 64'(redirect_valid_o), 64'h1);
    chk("miss_pc", redirect_pc_o, 64'h8000_0100);
    chk("miss_kill_last", 64'(fetch_kill_o), 64'h1);
    idle();
    chk("miss_back_run", 64'(fetch_kill_o), 64'h0);

    // Branch held off by MEM
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1, 1, 64'h8000_0200);
      chk("memblk_flush", 64'(flush_o), 64'h0);
      chk("memblk_rv", 64'(redirect_valid_o), 64'h0);
    end
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0200);
    chk("memblk_go_flush", 64'(flush_o), 64'h1);
    chk("memblk_go_pc", redirect_pc_o, 64'h8000_0200);
    idle();

    // Reset while waiting for the fetch
    cyc(0, 1, 0, 0, 0, 1, 64'h1234_5678);
    cyc(0, 1, 0, 0, 0, 0, 64'h0);
    cyc(1, 1, 0, 0, 0, 0, 64'h0);
    chk("wfrst_stall", 64'(stall_o), 64'h0);
    chk("wfrst_kill", 64'(fetch_kill_o), 64'h0);
    chk("wfrst_pc", redirect_pc_o, 64'h0);
    cyc(0, 1, 0, 0, 0, 0, 64'h0);
    chk("wfrst_cnt", 64'(stall_cnt_o), 64'h0);
    cyc(0, 0, 0, 0, 0, 0, 64'h0);
    chk("wfrst_no_rv", 64'(redirect_valid_o), 64'h0);
    chk("wfrst_no_kill", 64'(fetch_kill_o), 64'h0);

    // Counter saturation
    do_rst();
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0, 64'h0);
    idle();
    chk("cnt_sat", 64'(stall_cnt_o), 64'(CNT_MAX));

    // Randomized traffic
    do_rst();
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
          {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
